// File: rtl/weight_buffer_pkg.sv
// Package: weight_buffer_pkg
// Geometry and FSM encoding shared by the weight buffer and its loader.
//   X_PE, X_MESH   : PE array shape
//   DATA_LEN       : stream / buffer write word width
//   ADDR_LEN       : line address width (RAM_DEPTH = 2**ADDR_LEN lines)
//   WORDS_PER_LINE : DATA_LEN-bit words per kernel line (8-bit 3x3 weights per PE)
//   wb_state_e     : loader FSM states IDLE / XFER / DONE
package weight_buffer_pkg;

  localparam int X_PE           = 16;
  localparam int X_MESH         = 16;
  localparam int DATA_LEN       = 64;
  localparam int ADDR_LEN       = 9;
  localparam int RAM_DEPTH      = 2 ** ADDR_LEN;
  localparam int WORDS_PER_LINE = X_PE * X_MESH * 8 * 9 / DATA_LEN;

  // Word-within-line counter width and whole-command word count width
  localparam int WCNT_W  = $clog2(WORDS_PER_LINE);
  localparam int TOTAL_W = ADDR_LEN + 1 + WCNT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } wb_state_e;

endpackage

// File: rtl/weight_loader_skid.sv
// Module: weight_loader_skid
// Two-entry skid FIFO between the weight stream and the buffer write port.
// Caller guarantees no push when full and no pop when empty.
//   clk, rst_n : clock, asynchronous active-low reset (entries cleared to 0)
//   i_push     : write i_data this cycle
//   i_data     : incoming word
//   i_pop      : head word consumed this cycle
//   o_data     : head word (stable until popped)
//   o_valid    : FIFO non-empty
//   o_full     : both entries occupied
module weight_loader_skid
  import weight_buffer_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_push,
  input  logic [DATA_LEN-1:0] i_data,
  input  logic                i_pop,
  output logic [DATA_LEN-1:0] o_data,
  output logic                o_valid,
  output logic                o_full
);

  logic [DATA_LEN-1:0] r_mem [2];
  logic                r_wptr;
  logic                r_rptr;
  logic [1:0]          r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (i_pop) begin
        r_rptr <= ~r_rptr;
      end
      // Push and pop together leave occupancy unchanged
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_valid = (r_cnt != 2'd0);
  assign o_full  = (r_cnt == 2'd2);

endmodule

// File: rtl/weight_loader.sv
// Module: weight_loader
// Feeds the weight buffer: takes a load command (base line, line count) and a
// DATA_LEN-bit word stream, and writes WORDS_PER_LINE words per line to the
// buffer write port under wr_ready back-pressure.
// Handshakes: a word moves on s_* when s_valid && s_ready, on the write port
// when wr_en && wr_ready, and a command is taken when cmd_valid && cmd_ready;
// in every case the producer holds its payload until the transfer cycle.
//   cmd_valid/cmd_ready/cmd_base_addr/cmd_lines : load command (lines 0..RAM_DEPTH)
//   s_data/s_valid/s_ready                      : weight word stream
//   data_wr/st_wr_addr/wr_en/wr_ready           : buffer write port
//   busy                                        : command accepted and not yet finished
//   done                                        : one-cycle pulse when the command completes
// Optional build macro WL_CHECKSUM_EN adds output checksum (XOR of all words
// written by the current command; cleared on accept, held after done).
module weight_loader
  import weight_buffer_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_LEN-1:0] cmd_base_addr,
  input  logic [ADDR_LEN:0]   cmd_lines,
  input  logic [DATA_LEN-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [DATA_LEN-1:0] data_wr,
  output logic [ADDR_LEN-1:0] st_wr_addr,
  output logic                wr_en,
  input  logic                wr_ready,
  output logic                busy,
  output logic                done
`ifdef WL_CHECKSUM_EN
  ,
  output logic [DATA_LEN-1:0] checksum
`endif
);

  localparam logic [TOTAL_W-1:0]  WPL_T     = TOTAL_W'(WORDS_PER_LINE);
  localparam logic [TOTAL_W-1:0]  ONE_T     = TOTAL_W'(1);
  localparam logic [WCNT_W-1:0]   LAST_WORD = WCNT_W'(WORDS_PER_LINE - 1);
  localparam logic [WCNT_W-1:0]   ONE_W     = WCNT_W'(1);
  localparam logic [ADDR_LEN:0]   ONE_L     = (ADDR_LEN + 1)'(1);
  localparam logic [ADDR_LEN-1:0] ONE_A     = ADDR_LEN'(1);

  wb_state_e           r_state;
  wb_state_e           w_next_state;
  logic                r_live;       // low during reset and until the first edge after it
  logic [ADDR_LEN:0]   r_lines;
  logic [ADDR_LEN:0]   r_line_cnt;
  logic [WCNT_W-1:0]   r_word_cnt;
  logic [ADDR_LEN-1:0] r_addr;
  logic [TOTAL_W-1:0]  r_acc_left;   // words still to be accepted from the stream

  logic                w_accept;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_skid_valid;
  logic [DATA_LEN-1:0] w_skid_data;
  logic                w_last_word;
  logic                w_last_line;

  assign cmd_ready   = r_live && (r_state == IDLE);
  assign w_accept    = cmd_valid && cmd_ready;
  // s_ready is built only from registers, so wr_ready never reaches it combinationally
  assign s_ready     = (r_state == XFER) && !w_full && (r_acc_left != '0);
  assign w_push      = s_valid && s_ready;
  assign wr_en       = w_skid_valid;
  assign w_pop       = w_skid_valid && wr_ready && (r_state == XFER);
  assign data_wr     = w_skid_data;
  assign st_wr_addr  = r_addr;
  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign w_last_word = (r_word_cnt == LAST_WORD);
  assign w_last_line = (r_line_cnt == (r_lines - ONE_L));

  weight_loader_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (s_data),
    .i_pop   (w_pop),
    .o_data  (w_skid_data),
    .o_valid (w_skid_valid),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = (cmd_lines == '0) ? DONE : XFER;
        end
      end
      XFER: begin
        if (w_pop && w_last_word && w_last_line) begin
          w_next_state = DONE;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lines    <= '0;
      r_line_cnt <= '0;
      r_word_cnt <= '0;
      r_addr     <= '0;
      r_acc_left <= '0;
    end else if (w_accept) begin
      r_lines    <= cmd_lines;
      r_line_cnt <= '0;
      r_word_cnt <= '0;
      r_addr     <= cmd_base_addr;
      r_acc_left <= TOTAL_W'(cmd_lines) * WPL_T;
    end else begin
      if (w_push) begin
        r_acc_left <= r_acc_left - ONE_T;
      end
      if (w_pop) begin
        if (w_last_word) begin
          r_word_cnt <= '0;
          r_line_cnt <= r_line_cnt + ONE_L;
          // Address wraps naturally at RAM_DEPTH
          r_addr     <= r_addr + ONE_A;
        end else begin
          r_word_cnt <= r_word_cnt + ONE_W;
        end
      end
    end
  end

`ifdef WL_CHECKSUM_EN
  logic [DATA_LEN-1:0] r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= '0;
    end else if (w_pop) begin
      r_checksum <= r_checksum ^ w_skid_data;
    end
  end

  assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_weight_loader.sv
module tb_weight_loader;
  import weight_buffer_pkg::*;

  // ---------------- clock / reset ----------------
  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [ADDR_LEN-1:0] cmd_base_addr = '0;
  logic [ADDR_LEN:0]   cmd_lines = '0;
  logic [DATA_LEN-1:0] s_data = '0;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic [DATA_LEN-1:0] data_wr;
  logic [ADDR_LEN-1:0] st_wr_addr;
  logic                wr_en;
  logic                wr_ready = 1'b0;
  logic                busy;
  logic                done;
`ifdef WL_CHECKSUM_EN
  logic [DATA_LEN-1:0] checksum;
`endif

  always #5 clk = ~clk;

  weight_loader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_base_addr (cmd_base_addr),
    .cmd_lines     (cmd_lines),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .data_wr       (data_wr),
    .st_wr_addr    (st_wr_addr),
    .wr_en         (wr_en),
    .wr_ready      (wr_ready),
    .busy          (busy),
    .done          (done)
`ifdef WL_CHECKSUM_EN
    ,
    .checksum      (checksum)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [DATA_LEN-1:0] exp_q[$];
  logic [ADDR_LEN-1:0] exp_addr_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- driver / command engine ----------------
  // Issues one command and streams its words. Expected (word, line address)
  // pairs are queued when the DUT accepts a word; written words are popped
  // and compared. If abort_after > 0, rst_n is asserted after that many writes.
  task automatic run_cmd(input logic [ADDR_LEN-1:0] base, input logic [ADDR_LEN:0] lines,
                         input int vpct, input int rpct, input int abort_after,
                         input bit seq_data, input string name,
                         output int span, output logic [DATA_LEN-1:0] csum_dut);
    int total, sent, written, cyc, first_wr, last_wr, budget;
    bit done_seen, prev_stall;
    logic [DATA_LEN-1:0] prev_data, exp_d, model_csum;
    logic [ADDR_LEN-1:0] prev_addr, exp_a;
    total = int'(lines) * WORDS_PER_LINE;
    sent = 0; written = 0; cyc = 0; first_wr = -1; last_wr = -1;
    done_seen = 0; prev_stall = 0; model_csum = '0; csum_dut = '0;
    prev_data = '0; prev_addr = '0;
    budget = total * 10 + 50;

    @(negedge clk);
    cmd_valid = 1'b1; cmd_base_addr = base; cmd_lines = lines;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s cmd_ready: got %b expected 1", name, cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    while (cyc < budget) begin
      s_valid  = (sent < total) && ($urandom_range(99) < vpct);
      s_data   = seq_data ? DATA_LEN'(sent + 1) : {$urandom, $urandom};
      wr_ready = ($urandom_range(99) < rpct);
      #1;
      if (cyc == 0) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++; $display("FAIL %s busy_after_accept: got %b expected 1", name, busy);
        end
      end
      if (done === 1'b1) begin
        done_seen = 1;
        n_checks++;
        if (written != total) begin
          n_fail++; $display("FAIL %s done_early: writes %0d expected %0d", name, written, total);
        end
`ifdef WL_CHECKSUM_EN
        csum_dut = checksum;
        n_checks++;
        if (checksum !== model_csum) begin
          n_fail++; $display("FAIL %s checksum: got %h expected %h", name, checksum, model_csum);
        end
`endif
        break;
      end
      if (prev_stall) begin
        n_checks++;
        if (wr_en !== 1'b1 || data_wr !== prev_data || st_wr_addr !== prev_addr) begin
          n_fail++;
          $display("FAIL %s stall_stable: wr_en %b data %h addr %0d expected 1 %h %0d",
                   name, wr_en, data_wr, st_wr_addr, prev_data, prev_addr);
        end
      end
      if (sent >= total) begin
        n_checks++;
        if (s_ready !== 1'b0) begin
          n_fail++; $display("FAIL %s s_ready_over: got %b expected 0", name, s_ready);
        end
      end
      if (s_valid && s_ready === 1'b1) begin
        exp_q.push_back(s_data);
        exp_addr_q.push_back(ADDR_LEN'(int'(base) + sent / WORDS_PER_LINE));
        sent++;
      end
      if (wr_en === 1'b1 && wr_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL %s extra_write: data %h expected no write", name, data_wr);
        end else begin
          exp_d = exp_q.pop_front();
          exp_a = exp_addr_q.pop_front();
          model_csum = model_csum ^ exp_d;
          if (data_wr !== exp_d || st_wr_addr !== exp_a) begin
            n_fail++;
            $display("FAIL %s write_%0d: data %h addr %0d expected %h %0d",
                     name, written, data_wr, st_wr_addr, exp_d, exp_a);
          end
        end
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        written++;
        if (abort_after > 0 && written == abort_after) begin
          #2 rst_n = 1'b0;
          #1;
          s_valid = 1'b0; wr_ready = 1'b0;
          exp_q.delete(); exp_addr_q.delete();
          span = last_wr - first_wr + 1;
          return;
        end
      end
      prev_stall = (wr_en === 1'b1) && !wr_ready;
      prev_data  = data_wr;
      prev_addr  = st_wr_addr;
      @(negedge clk);
      cyc++;
    end
    span = last_wr - first_wr + 1;
    n_checks++;
    if (!done_seen) begin
      n_fail++; $display("FAIL %s timeout: done 0 expected 1 within %0d cycles", name, budget);
    end
    s_valid = 1'b0; wr_ready = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s post_done: done %b busy %b cmd_ready %b pending %0d expected 0 0 1 0",
               name, done, busy, cmd_ready, exp_q.size());
    end
    exp_q.delete(); exp_addr_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (cmd_ready !== 1'b0 || s_ready !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || data_wr !== '0 || st_wr_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_state: cmd_ready %b s_ready %b wr_en %b busy %b done %b data %h addr %0d expected all 0",
               cmd_ready, s_ready, wr_en, busy, done, data_wr, st_wr_addr);
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release cmd_ready: got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_single_line();
    int span; logic [DATA_LEN-1:0] cs;
    run_cmd(9'd0, 10'd1, 100, 100, 0, 1'b0, "single_line", span, cs);
    n_checks++;
    if (span != WORDS_PER_LINE) begin
      n_fail++; $display("FAIL single_line back_to_back: span %0d expected %0d", span, WORDS_PER_LINE);
    end
  endtask

  task automatic test_wrap();
    int span; logic [DATA_LEN-1:0] cs;
    run_cmd(9'd510, 10'd3, 100, 100, 0, 1'b0, "wrap", span, cs);
    n_checks++;
    if (span != 3 * WORDS_PER_LINE) begin
      n_fail++; $display("FAIL wrap back_to_back: span %0d expected %0d", span, 3 * WORDS_PER_LINE);
    end
  endtask

  task automatic test_zero_lines();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_base_addr = 9'd3; cmd_lines = '0;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL zero_lines cmd_ready: got %b expected 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b1 || wr_en !== 1'b0 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_lines pulse: done %b busy %b wr_en %b s_ready %b expected 1 1 0 0",
               done, busy, wr_en, s_ready);
    end
    @(negedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_lines after: done %b busy %b cmd_ready %b expected 0 0 1", done, busy, cmd_ready);
    end
  endtask

  task automatic test_random_backpressure();
    int span; logic [DATA_LEN-1:0] cs;
    run_cmd(9'd37, 10'd2, 70, 50, 0, 1'b0, "random_bp", span, cs);
    run_cmd(9'd200, 10'd1, 40, 80, 0, 1'b0, "random_gaps", span, cs);
  endtask

  task automatic test_abort();
    int span; logic [DATA_LEN-1:0] cs;
    run_cmd(9'd5, 10'd2, 100, 100, 100, 1'b0, "abort", span, cs);
    // rst_n is now low, asserted between clock edges
    n_checks++;
    if (cmd_ready !== 1'b0 || s_ready !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || data_wr !== '0 || st_wr_addr !== '0) begin
      n_fail++;
      $display("FAIL abort async_reset: cmd_ready %b s_ready %b wr_en %b busy %b done %b data %h addr %0d expected all 0",
               cmd_ready, s_ready, wr_en, busy, done, data_wr, st_wr_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL abort no_done: done %b busy %b expected 0 0", done, busy);
      end
    end
    run_cmd(9'd100, 10'd1, 80, 80, 0, 1'b0, "after_abort", span, cs);
  endtask

`ifdef WL_CHECKSUM_EN
  task automatic test_checksum();
    int span; logic [DATA_LEN-1:0] cs;
    run_cmd(9'd7, 10'd1, 100, 100, 0, 1'b1, "checksum", span, cs);
    n_checks++;
    if (cs !== 64'd288) begin
      n_fail++; $display("FAIL checksum_seq: got %0d expected 288", cs);
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_line();
    test_wrap();
    test_zero_lines();
    test_random_backpressure();
    test_abort();
`ifdef WL_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
